// File: rtl/cmos_mode_ctrl.sv
// Camera mode controller: debounced keys cycle pending gamma/effect modes,
// committed only at frame start, followed by a frame-counted output mute.
module cmos_mode_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [2:0]  MUTE_FRAMES     = 3'd2
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       key_gamma,
  input  logic       key_effect,
  input  logic       vs_i,
  output logic [1:0] gamma_ctrl,
  output logic [1:0] saturation_ctrl,
  output logic       mute_o,
  output logic       pending_o,
  output logic       commit_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_MUTE = 2'd2;

  // Index 0 is the gamma key, index 1 the effect key.
  logic [1:0]       key_raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       stb_q, stb_d;
  logic [1:0]       stb_1d_q, stb_1d_d;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic [1:0]       press;

  logic [1:0] state_q, state_d;
  logic [1:0] pg_q, pg_d;
  logic [1:0] pe_q, pe_d;
  logic       dirty_q, dirty_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       vs_1d_q, vs_1d_d;
  logic [1:0] gamma_q, gamma_d;
  logic [1:0] sat_q, sat_d;
  logic       mute_q, mute_d;
  logic       commit_q, commit_d;
  logic       fs;

  assign key_raw = {key_effect, key_gamma};

  // Key path: two-flop synchronizer, stable-level debouncer, falling-edge press.
  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stb_1d_d = stb_q;
    stb_d    = stb_q;
    cnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
          stb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
    press = stb_1d_q & ~stb_q;
  end

  // Key path registers; keys idle high so the chain resets to 1.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      stb_q    <= 2'b11;
      stb_1d_q <= 2'b11;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stb_q    <= stb_d;
      stb_1d_q <= stb_1d_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pending modes, dirty flag and commit/mute sequencing.
  always_comb begin
    fs       = vs_i & ~vs_1d_q;
    vs_1d_d  = vs_i;
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    gamma_d  = gamma_q;
    sat_d    = sat_q;
    mute_d   = mute_q;
    commit_d = 1'b0;
    pg_d     = pg_q;
    pe_d     = pe_q;
    dirty_d  = dirty_q;
    if (press[0]) begin
      pg_d = (pg_q == 2'd2) ? 2'd0 : pg_q + 2'd1;
    end
    if (press[1]) begin
      pe_d = (pe_q == 2'd2) ? 2'd0 : pe_q + 2'd1;
    end
    if (|press) begin
      dirty_d = 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (|press) begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (fs) begin
          // Commit the pre-press values; a same-cycle press stays pending.
          gamma_d  = pg_q;
          sat_d    = pe_q;
          commit_d = 1'b1;
          mute_d   = 1'b1;
          fcnt_d   = MUTE_FRAMES;
          state_d  = S_MUTE;
          if (!(|press)) begin
            dirty_d = 1'b0;
          end
        end
      end
      S_MUTE: begin
        if (fs) begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q == 3'd1) begin
            mute_d  = 1'b0;
            state_d = dirty_d ? S_PEND : S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pg_q     <= 2'd0;
      pe_q     <= 2'd0;
      dirty_q  <= 1'b0;
      fcnt_q   <= 3'd0;
      vs_1d_q  <= 1'b0;
      gamma_q  <= 2'd0;
      sat_q    <= 2'd0;
      mute_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pg_q     <= pg_d;
      pe_q     <= pe_d;
      dirty_q  <= dirty_d;
      fcnt_q   <= fcnt_d;
      vs_1d_q  <= vs_1d_d;
      gamma_q  <= gamma_d;
      sat_q    <= sat_d;
      mute_q   <= mute_d;
      commit_q <= commit_d;
    end
  end

  assign gamma_ctrl      = gamma_q;
  assign saturation_ctrl = sat_q;
  assign mute_o          = mute_q;
  assign pending_o       = dirty_q;
  assign commit_o        = commit_q;

endmodule
